// File: rtl/led_step_ctrl_if.sv
// Button-side inputs and colour-datapath strobes of the LED step controller.
// The bench drives master; led_step_ctrl connects as slave.
interface led_step_ctrl_if;
  logic       button;
  logic       auto_mode;
  logic       advance;
  logic       colour_clr;
  logic       held;
  logic [7:0] step_cnt;

  modport master (
    output button,
    output auto_mode,
    input  advance,
    input  colour_clr,
    input  held,
    input  step_cnt
  );

  modport slave (
    input  button,
    input  auto_mode,
    output advance,
    output colour_clr,
    output held,
    output step_cnt
  );
endinterface

// File: rtl/led_step_ctrl.sv
// Push-button conditioning and advance/clear strobe sequencing for the LED colour datapath.
// Optional free-running mode: define LED_STEP_CTRL_AUTO_EN.
module led_step_ctrl #(
  parameter int DEB_CYCLES  = 4,
  parameter int STEP_CYCLES = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  led_step_ctrl_if.slave bus
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TW = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] T_PRE    = TW'(STEP_CYCLES - 2);
  localparam logic [TW-1:0] T_LAST   = TW'(STEP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_FIRST,
    S_REPEAT
`ifdef LED_STEP_CTRL_AUTO_EN
    , S_AUTO
`endif
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [CW-1:0]   deb_cnt_q, deb_cnt_d;
  logic            held_q, held_d;
  logic            rise_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic            adv_q, adv_d;
  logic            clr_q, clr_d;
  logic [7:0]      step_q, step_d;

`ifndef LED_STEP_CTRL_AUTO_EN
  logic unused_auto;
  assign unused_auto = bus.auto_mode;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_cnt_q <= '0;
      held_q    <= 1'b0;
      rise_q    <= 1'b0;
      timer_q   <= '0;
      adv_q     <= 1'b0;
      clr_q     <= 1'b0;
      step_q    <= 8'd0;
    end else begin
      sync1_q   <= bus.button;
      sync2_q   <= sync1_q;
      deb_cnt_q <= deb_cnt_d;
      held_q    <= held_d;
      rise_q    <= held_d & ~held_q;
      timer_q   <= timer_d;
      adv_q     <= adv_d;
      clr_q     <= clr_d;
      step_q    <= step_d;
    end
  end

  // held only flips after DEB_CYCLES consecutive disagreeing samples
  always_comb begin
    deb_cnt_d = '0;
    held_d    = held_q;
    if (sync2_q != held_q) begin
      if (deb_cnt_q == DEB_LAST) held_d = ~held_q;
      else deb_cnt_d = deb_cnt_q + CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (rise_q && held_d) state_d = S_FIRST;
`ifdef LED_STEP_CTRL_AUTO_EN
        else if (bus.auto_mode && !held_q)
          state_d = S_AUTO;
`endif
      end
      S_FIRST:  state_d = S_REPEAT;
      S_REPEAT: if (!held_d) state_d = S_IDLE;
`ifdef LED_STEP_CTRL_AUTO_EN
      S_AUTO:   if (!bus.auto_mode) state_d = S_IDLE;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes are decided one cycle ahead and registered; the visible
  // advance coincides with timer_q == STEP_CYCLES-1.
  always_comb begin
    adv_d   = 1'b0;
    clr_d   = 1'b0;
    timer_d = timer_q;
    case (state_q)
      S_INIT: clr_d = 1'b1;
      S_IDLE: begin
        timer_d = '0;
        adv_d   = rise_q && held_d;
      end
      S_FIRST: timer_d = '0;
      S_REPEAT: begin
        if (!held_d) begin
          timer_d = '0;
        end else begin
          adv_d   = (timer_q == T_PRE);
          timer_d = (timer_q == T_LAST) ? '0
                                        : timer_q + TW'(1);
        end
      end
`ifdef LED_STEP_CTRL_AUTO_EN
      S_AUTO: begin
        if (!bus.auto_mode) begin
          timer_d = '0;
        end else if (!held_d) begin
          adv_d   = (timer_q == T_PRE);
          timer_d = (timer_q == T_LAST) ? '0
                                        : timer_q + TW'(1);
        end
      end
`endif
      default: timer_d = '0;
    endcase
  end

  assign step_d = adv_d ? step_q + 8'd1 : step_q;

  assign bus.advance    = adv_q;
  assign bus.colour_clr = clr_q;
  assign bus.held       = held_q;
  assign bus.step_cnt   = step_q;
endmodule

// File: tb/tb_led_step_ctrl.sv
// Directed-vector bench for led_step_ctrl: reset, press/repeat, glitch,
// counter wrap, auto mode and mid-operation reset.
module tb_led_step_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  led_step_ctrl_if bus();
  led_step_ctrl_if bus2();

  always #5 clk = ~clk;

  led_step_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  led_step_ctrl #(
    .DEB_CYCLES  (4),
    .STEP_CYCLES (2)
  ) u_fast (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] m;
    logic [127:0] want;
    logic [127:0] hr;
    logic [127:0] cl;
    int           advs;
    int           clrs;
    logic         prev;
    logic         b2b;
    logic [7:0]   c255;
    logic [7:0]   c0;
    logic [7:0]   deb4;

    rst_n          = 1'b0;
    bus.button     = 1'b0;
    bus.auto_mode  = 1'b0;
    bus2.button    = 1'b0;
    bus2.auto_mode = 1'b0;
    #12;
    chk("rst_adv",  bus.advance,    0);
    chk("rst_clr",  bus.colour_clr, 0);
    chk("rst_held", bus.held,       0);
    chk("rst_cnt",  bus.step_cnt,   0);

    // release, then idle for 100 cycles
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("clr_pulse", bus.colour_clr, 1);
    advs = 0;
    clrs = 0;
    for (int e = 1; e <= 100; e++) begin
      tick;
      advs += int'(bus.advance);
      clrs += int'(bus.colour_clr);
    end
    chk("idle_adv", advs, 0);
    chk("idle_clr", clrs, 0);
    chk("idle_cnt", bus.step_cnt, 0);

    // press: button high before edges 0..23
    m  = '0;
    hr = '0;
    for (int e = 0; e < 40; e++) begin
      bus.button = (e < 24);
      tick;
      m[e]  = bus.advance;
      hr[e] = bus.held;
    end
    want = '0;
    want[6]  = 1'b1;
    want[14] = 1'b1;
    want[22] = 1'b1;
    chk("press_adv",  m, want);
    chk("held_rise",  hr[5:4],   2'b10);
    chk("held_fall",  hr[29:28], 2'b01);
    chk("press_cnt",  bus.step_cnt, 3);

    // 3-cycle glitch
    m    = '0;
    hr   = '0;
    deb4 = '0;
    for (int e = 0; e < 16; e++) begin
      bus.button = (e < 3);
      tick;
      m[e]  = bus.advance;
      hr[e] = bus.held;
      if (e == 4) deb4 = 8'(u_dut.deb_cnt_q);
    end
    chk("glitch_adv",  m,  0);
    chk("glitch_held", hr, 0);
    chk("glitch_peak", deb4, 3);
    chk("glitch_deb",  u_dut.deb_cnt_q, 0);
    chk("glitch_cnt",  bus.step_cnt, 3);

    // wrap on STEP_CYCLES=2 instance: strobes at 6,8,..,518
    bus2.button = 1'b1;
    prev = 1'b0;
    b2b  = 1'b0;
    advs = 0;
    c255 = '0;
    c0   = 8'hff;
    for (int e = 0; e < 520; e++) begin
      tick;
      if (bus2.advance) begin
        advs++;
        if (prev) b2b = 1'b1;
      end
      prev = bus2.advance;
      if (e == 514) c255 = bus2.step_cnt;
      if (e == 516) c0 = bus2.step_cnt;
    end
    chk("wrap_255",  c255, 255);
    chk("wrap_0",    c0,   0);
    chk("wrap_b2b",  b2b,  0);
    chk("wrap_advs", advs, 257);
    bus2.button = 1'b0;
    repeat (12) tick;

    // auto mode with a press before edges 40..59
    bus.auto_mode = 1'b1;
    m = '0;
    for (int e = 0; e < 100; e++) begin
      bus.button = (e >= 40 && e < 60);
      tick;
      m[e] = bus.advance;
    end
    want = '0;
`ifdef LED_STEP_CTRL_AUTO_EN
    want[7]  = 1'b1;
    want[15] = 1'b1;
    want[23] = 1'b1;
    want[31] = 1'b1;
    want[39] = 1'b1;
    want[67] = 1'b1;
    want[75] = 1'b1;
    want[83] = 1'b1;
    want[91] = 1'b1;
    want[99] = 1'b1;
`else
    want[46] = 1'b1;
    want[54] = 1'b1;
    want[62] = 1'b1;
`endif
    chk("auto_adv", m, want);
    bus.auto_mode = 1'b0;
    bus.button    = 1'b0;
    advs = 0;
    for (int e = 0; e < 12; e++) begin
      tick;
      advs += int'(bus.advance);
    end
    chk("auto_off_adv", advs, 0);
`ifdef LED_STEP_CTRL_AUTO_EN
    chk("auto_cnt", bus.step_cnt, 13);
`else
    chk("auto_cnt", bus.step_cnt, 6);
`endif

    // reset while REPEAT timer = 5, button kept high
    bus.button = 1'b1;
    for (int e = 0; e < 13; e++) tick;
    chk("pre_rst_timer", u_dut.timer_q, 5);
    chk("pre_rst_held",  bus.held, 1);
    rst_n = 1'b0;
    #1;
    chk("async_adv",  bus.advance,    0);
    chk("async_clr",  bus.colour_clr, 0);
    chk("async_held", bus.held,       0);
    chk("async_cnt",  bus.step_cnt,   0);
    @(negedge clk);
    rst_n = 1'b1;
    m  = '0;
    cl = '0;
    for (int e = 0; e < 12; e++) begin
      tick;
      m[e]  = bus.advance;
      cl[e] = bus.colour_clr;
    end
    want = '0;
    want[6] = 1'b1;
    chk("rst2_clr", cl, 1);
    chk("rst2_adv", m, want);
    chk("rst2_cnt", bus.step_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
